// File: rtl/fetch_line_unit.sv
// Instruction fetch stage: caches one memory line and serves sequential PCs from it,
// stalls after control-flow opcodes until the store stage redirects.
package fetch_line_unit_pkg;

    typedef enum logic [7:0] {
        NOP             = 8'h00,
        ADD             = 8'h01,
        LOAD            = 8'h02,
        STORE           = 8'h03,
        HALT            = 8'h0F,
        JMP_ALWAYS      = 8'h10,
        JMP_IF_ZERO     = 8'h11,
        JMP_IF_NONZERO  = 8'h12,
        LOAD_RESTORE_PC = 8'h20
    } Opcode;

    function automatic logic changesControlFlow(input Opcode op);
        case (op)
            HALT, JMP_ALWAYS, JMP_IF_ZERO, JMP_IF_NONZERO, LOAD_RESTORE_PC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

module fetch_line_unit
    import fetch_line_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       INSN_W     = 32,
    parameter int unsigned       LINE_WORDS = 2,
    parameter int unsigned       MASK_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [MASK_W-1:0] RESET_MASK = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic [MASK_W-1:0]            redirect_mask,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ADDR_W-1:0]            mem_req_addr,
    input  logic                         mem_rsp_valid,
    input  logic [INSN_W*LINE_WORDS-1:0] mem_rsp_data,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [ADDR_W-1:0]            dec_pc,
    output logic [INSN_W-1:0]            dec_insn,
    output logic [MASK_W-1:0]            dec_mask
);

    localparam int unsigned INSN_BYTES = INSN_W / 8;
    localparam int unsigned LINE_BYTES = LINE_WORDS * INSN_BYTES;
    localparam int unsigned LINE_W     = INSN_W * LINE_WORDS;
    localparam int unsigned INSN_OFF   = $clog2(INSN_BYTES);
    localparam int unsigned LINE_OFF   = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {LOOKUP, REQ, WAIT, ISSUE, STALL_JMP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [MASK_W-1:0]   exec_mask_q, exec_mask_d;
    logic [ADDR_W-1:0]   line_tag_q, line_tag_d;
    logic                line_valid_q, line_valid_d;
    logic [LINE_W-1:0]   line_data_q, line_data_d;
    logic                drop_rsp_q, drop_rsp_d;
    logic [ADDR_W-1:0]   dec_pc_q, dec_pc_d;
    logic [INSN_W-1:0]   dec_insn_q, dec_insn_d;
    logic [MASK_W-1:0]   dec_mask_q, dec_mask_d;

    logic [ADDR_W-1:0]   aligned_pc;
    logic [IDX_W-1:0]    word_idx;
    logic [INSN_W-1:0]   cur_word;
    logic                hit;

    generate
        if (LINE_WORDS > 1) begin : g_idx
            assign word_idx = fetch_pc_q[LINE_OFF-1:INSN_OFF];
        end else begin : g_idx_single
            assign word_idx = '0;
        end
    endgenerate

    assign aligned_pc = fetch_pc_q & ~OFF_MASK;
    assign cur_word   = line_data_q[word_idx*INSN_W +: INSN_W];
    assign hit        = line_valid_q && (line_tag_q == aligned_pc);

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = aligned_pc;
    assign dec_valid     = (state_q == ISSUE);
    assign dec_pc        = dec_pc_q;
    assign dec_insn      = dec_insn_q;
    assign dec_mask      = dec_mask_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        exec_mask_d  = exec_mask_q;
        line_tag_d   = line_tag_q;
        line_valid_d = line_valid_q;
        line_data_d  = line_data_q;
        drop_rsp_d   = drop_rsp_q;
        dec_pc_d     = dec_pc_q;
        dec_insn_d   = dec_insn_q;
        dec_mask_d   = dec_mask_q;

        case (state_q)
            LOOKUP: begin
                if (hit) begin
                    dec_pc_d   = fetch_pc_q;
                    dec_insn_d = cur_word;
                    dec_mask_d = exec_mask_q;
                    state_d    = ISSUE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    if (drop_rsp_q) begin
                        drop_rsp_d = 1'b0;
                    end else begin
                        line_data_d  = mem_rsp_data;
                        line_tag_d   = aligned_pc;
                        line_valid_d = 1'b1;
                    end
                    state_d = LOOKUP;
                end
            end
            ISSUE: begin
                if (dec_ready) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(INSN_BYTES);
                    state_d    = changesControlFlow(Opcode'(dec_insn_q[7:0])) ? STALL_JMP : LOOKUP;
                end
            end
            default: ;
        endcase

        // Redirect overrides everything; an outstanding read is still owed a response,
        // so we wait it out with drop_rsp set unless it is arriving right now.
        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc;
            exec_mask_d  = redirect_mask;
            line_tag_d   = line_tag_q;
            line_valid_d = line_valid_q;
            line_data_d  = line_data_q;
            state_d      = LOOKUP;
            if (state_q == WAIT) begin
                drop_rsp_d = !mem_rsp_valid;
                state_d    = mem_rsp_valid ? LOOKUP : WAIT;
            end else if (state_q == REQ && mem_req_ready) begin
                drop_rsp_d = 1'b1;
                state_d    = WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOOKUP;
            fetch_pc_q   <= RESET_PC;
            exec_mask_q  <= RESET_MASK;
            line_tag_q   <= '0;
            line_valid_q <= 1'b0;
            line_data_q  <= '0;
            drop_rsp_q   <= 1'b0;
            dec_pc_q     <= '0;
            dec_insn_q   <= '0;
            dec_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            exec_mask_q  <= exec_mask_d;
            line_tag_q   <= line_tag_d;
            line_valid_q <= line_valid_d;
            line_data_q  <= line_data_d;
            drop_rsp_q   <= drop_rsp_d;
            dec_pc_q     <= dec_pc_d;
            dec_insn_q   <= dec_insn_d;
            dec_mask_q   <= dec_mask_d;
        end
    end

endmodule

// File: tb/tb_fetch_line_unit.sv
// Bench for fetch_line_unit: directed scenarios plus randomized traffic, checked against
// an instruction-stream model (expected next PC, mask, stall) and a latency-randomized memory.
module tb_fetch_line_unit;
    import fetch_line_unit_pkg::*;

    localparam int ADDR_W = 64;
    localparam int INSN_W = 32;
    localparam int LINE_WORDS = 2;
    localparam int MASK_W = 64;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         redirect_valid = 1'b0;
    logic [ADDR_W-1:0]            redirect_pc = '0;
    logic [MASK_W-1:0]            redirect_mask = '0;
    logic                         mem_req_valid;
    logic                         mem_req_ready = 1'b0;
    logic [ADDR_W-1:0]            mem_req_addr;
    logic                         mem_rsp_valid = 1'b0;
    logic [INSN_W*LINE_WORDS-1:0] mem_rsp_data = '0;
    logic                         dec_valid;
    logic                         dec_ready = 1'b0;
    logic [ADDR_W-1:0]            dec_pc;
    logic [INSN_W-1:0]            dec_insn;
    logic [MASK_W-1:0]            dec_mask;

    fetch_line_unit #(
        .ADDR_W(ADDR_W), .INSN_W(INSN_W), .LINE_WORDS(LINE_WORDS), .MASK_W(MASK_W),
        .RESET_PC('0), .RESET_MASK('1)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_mask(redirect_mask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_insn(dec_insn), .dec_mask(dec_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Program memory: explicit overrides, otherwise a fixed hash of the address.
    logic [31:0] mem_ovr [logic [63:0]];

    function automatic logic [31:0] insn_at(input logic [63:0] a);
        logic [31:0] h;
        logic [7:0]  op;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
        case (h[15:12])
            4'd0:    op = JMP_ALWAYS;
            4'd1:    op = HALT;
            4'd2:    op = LOAD_RESTORE_PC;
            4'd3:    op = JMP_IF_NONZERO;
            default: op = {6'b0, h[1:0]};
        endcase
        return {h[31:8], op};
    endfunction

    function automatic logic [63:0] line_at(input logic [63:0] a);
        return {insn_at(a + 64'd4), insn_at(a)};
    endfunction

    function automatic bit is_cf(input logic [7:0] op);
        return op inside {HALT, JMP_ALWAYS, JMP_IF_ZERO, JMP_IF_NONZERO, LOAD_RESTORE_PC};
    endfunction

    // Model state
    logic [63:0] exp_pc;
    logic [63:0] exp_mask;
    bit          stalled;
    int          cyc = 0;
    int          last_issue = 0;
    bit          hold_pending = 0;
    logic [63:0] prev_pc, prev_mask;
    logic [31:0] prev_insn;
    logic [63:0] rsp_addr[$];
    int          rsp_due[$];
    logic [63:0] req_log[$];
    logic [63:0] issued[$];

    int dec_rdy_pct = 100;
    int mem_rdy_pct = 100;
    int lat_min = 1;
    int lat_max = 1;

    task automatic step(input bit redir = 0, input logic [63:0] rpc = '0, input logic [63:0] rmask = '0);
        logic [31:0] winsn;
        @(negedge clk);
        cyc++;
        dec_ready     = ($urandom_range(99) < dec_rdy_pct);
        mem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (rsp_addr.size() > 0 && rsp_due[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line_at(rsp_addr.pop_front());
            void'(rsp_due.pop_front());
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        redirect_mask  = rmask;
        #1;
        if (hold_pending) begin
            check_val("hold_valid", dec_valid, 1'b1);
            check_val("hold_pc", dec_pc, prev_pc);
            check_val("hold_insn", dec_insn, prev_insn);
            check_val("hold_mask", dec_mask, prev_mask);
        end
        hold_pending = dec_valid && !dec_ready && !redir;
        prev_pc = dec_pc; prev_insn = dec_insn; prev_mask = dec_mask;
        if (stalled) begin
            check_val("stall_dec_valid", dec_valid, 1'b0);
            check_val("stall_req_valid", mem_req_valid, 1'b0);
        end
        if (mem_req_valid) check_val("req_aligned", mem_req_addr[2:0], 3'd0);
        if (mem_req_valid && mem_req_ready) begin
            rsp_addr.push_back(mem_req_addr);
            rsp_due.push_back(cyc + $urandom_range(lat_max, lat_min));
            req_log.push_back(mem_req_addr);
        end
        if (dec_valid && dec_ready) begin
            winsn = insn_at(exp_pc);
            check_val("dec_pc", dec_pc, exp_pc);
            check_val("dec_insn", dec_insn, winsn);
            check_val("dec_mask", dec_mask, exp_mask);
            issued.push_back(dec_pc);
            last_issue = cyc;
            if (is_cf(winsn[7:0])) stalled = 1;
            else exp_pc = exp_pc + 64'd4;
        end
        if (redir) begin
            exp_pc = rpc; exp_mask = rmask; stalled = 0; last_issue = cyc;
        end
        if (!stalled && (cyc - last_issue) > 300) begin
            check_val("progress_gap", cyc - last_issue, 300);
            last_issue = cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; dec_ready = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_req_valid", mem_req_valid, 1'b0);
        check_val("rst_dec_valid", dec_valid, 1'b0);
        check_val("rst_dec_pc", dec_pc, 64'd0);
        check_val("rst_dec_insn", dec_insn, 32'd0);
        check_val("rst_dec_mask", dec_mask, 64'd0);
        reset = 1'b0;
        exp_pc = '0; exp_mask = '1; stalled = 0; hold_pending = 0; last_issue = cyc;
        rsp_addr.delete(); rsp_due.delete(); req_log.delete();
    endtask

    task automatic run_until_issue(input int maxc);
        int n0;
        n0 = issued.size();
        for (int i = 0; i < maxc && issued.size() == n0; i++) step();
        check_val("issue_timeout", issued.size() != n0, 1'b1);
    endtask

    task automatic run_until_stall(input int maxc);
        for (int i = 0; i < maxc && !stalled; i++) step();
        check_val("stall_timeout", stalled, 1'b1);
    endtask

    task automatic wait_new_req(input int maxc);
        int n0;
        n0 = req_log.size();
        for (int i = 0; i < maxc && req_log.size() == n0; i++) step();
        check_val("req_timeout", req_log.size() != n0, 1'b1);
    endtask

    initial begin
        int nreq, nq;
        logic [63:0] hpc, rpc, rmask;
        logic [31:0] hinsn;

        mem_ovr[64'h0]  = {24'h000001, 8'(NOP)};
        mem_ovr[64'h4]  = {24'h000002, 8'(NOP)};
        mem_ovr[64'h8]  = {24'h000003, 8'(ADD)};
        mem_ovr[64'hC]  = {24'h000004, 8'(HALT)};
        mem_ovr[64'h40] = {24'h000040, 8'(NOP)};
        mem_ovr[64'h44] = {24'h000044, 8'(JMP_ALWAYS)};

        do_reset();

        // Sequential run across a line boundary, ending on HALT at 0xC
        lat_min = 2; lat_max = 2;
        run_until_stall(80);
        check_val("seq_req_count", req_log.size(), 2);
        check_val("seq_req0", req_log[0], 64'h0);
        check_val("seq_req1", req_log[1], 64'h8);
        check_val("seq_issue_count", issued.size(), 4);
        check_val("seq_last_pc", issued[3], 64'hC);
        nreq = req_log.size();
        repeat (10) step();
        check_val("halt_stall_reqs", req_log.size(), nreq);

        // Jump at 0x44 stalls until redirect to 0x80 with mask 0x5
        step(1, 64'h40, '1);
        run_until_stall(80);
        check_val("jmp_src_pc", issued[$], 64'h44);
        nreq = req_log.size();
        repeat (10) step();
        check_val("jmp_stall_reqs", req_log.size(), nreq);
        step(1, 64'h80, 64'h5);
        run_until_issue(60);
        check_val("jmp_tgt_pc", issued[$], 64'h80);

        // Redirect to 0x100 while waiting on the 0x1000 line
        lat_min = 8; lat_max = 8;
        step(1, 64'h1000, 64'h33);
        nq = req_log.size();
        wait_new_req(20);
        step(); step();
        step(1, 64'h100, 64'hF0F0);
        run_until_issue(80);
        check_val("drop_req0", req_log[nq], 64'h1000);
        check_val("drop_req1", req_log[nq+1], 64'h100);
        check_val("drop_issue_pc", issued[$], 64'h100);

        // Decode back-pressure on pc 0x4
        lat_min = 1; lat_max = 3;
        dec_rdy_pct = 0;
        step(1, 64'h4, 64'hA);
        for (int i = 0; i < 40 && !dec_valid; i++) step();
        check_val("bp_valid", dec_valid, 1'b1);
        hpc = dec_pc; hinsn = dec_insn;
        repeat (5) step();
        check_val("bp_pc_stable", dec_pc, hpc);
        check_val("bp_insn_stable", dec_insn, hinsn);
        check_val("bp_pc_value", dec_pc, 64'h4);
        dec_rdy_pct = 100;
        run_until_issue(10);
        check_val("bp_accept_pc", issued[$], 64'h4);

        // Randomized traffic including redirects near the top of the address space
        for (int blk = 0; blk < 30; blk++) begin
            dec_rdy_pct = $urandom_range(100, 30);
            mem_rdy_pct = $urandom_range(100, 30);
            lat_min = 1;
            lat_max = $urandom_range(6, 1);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(99) < (stalled ? 10 : 3)) begin
                    if ($urandom_range(3) == 3) rpc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'({$urandom_range(7), 2'b00});
                    else rpc = 64'({$urandom_range(255), 2'b00});
                    rmask = {$urandom, $urandom};
                    step(1, rpc, rmask);
                end else begin
                    step();
                end
            end
        end

        // Reset while a read is outstanding
        dec_rdy_pct = 100; mem_rdy_pct = 100;
        lat_min = 20; lat_max = 20;
        step(1, 64'h2000, '1);
        wait_new_req(20);
        step(); step();
        do_reset();
        lat_min = 1; lat_max = 2;
        run_until_issue(40);
        check_val("post_rst_pc", issued[$], 64'h0);
        check_val("post_rst_req", req_log[0], 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
